// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing, mid-bit sampling after a 2-flop synchronizer,
// single-entry output buffer with read acknowledge, framing-error and overrun flags.
module uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       serial_in,
   input  logic       rd_ack,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       framing_error,
   output logic       overrun,
   output logic       busy
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   state_t        state_reg, state_next;
   logic          sync1_reg, rx_s;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [2:0]    idx_reg, idx_next;
   logic [7:0]    shift_reg, shift_next;
   logic [7:0]    data_reg, data_next;
   logic          valid_reg, valid_next;
   logic          fe_reg, fe_next;
   logic          ovr_reg, ovr_next;

   // Synchronizer idles high so reset never looks like a start bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_reg <= 1'b1;
         rx_s      <= 1'b1;
      end else begin
         sync1_reg <= serial_in;
         rx_s      <= sync1_reg;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         idx_reg   <= '0;
         shift_reg <= '0;
         data_reg  <= '0;
         valid_reg <= 1'b0;
         fe_reg    <= 1'b0;
         ovr_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         idx_reg   <= idx_next;
         shift_reg <= shift_next;
         data_reg  <= data_next;
         valid_reg <= valid_next;
         fe_reg    <= fe_next;
         ovr_reg   <= ovr_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg + CW'(1);
      idx_next   = idx_reg;
      shift_next = shift_reg;
      data_next  = data_reg;
      valid_next = valid_reg;
      fe_next    = 1'b0;
      ovr_next   = ovr_reg;
      if (rd_ack)
         valid_next = 1'b0;
      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            idx_next = '0;
            if (!rx_s)
               state_next = START;
         end
         START: begin
            if (cnt_reg == HALF_M1) begin
               cnt_next   = '0;
               state_next = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_reg == FULL_M1) begin
               cnt_next   = '0;
               shift_next = {rx_s, shift_reg[7:1]};
               idx_next   = idx_reg + 3'd1;
               if (idx_reg == 3'd7)
                  state_next = STOP;
            end
         end
         STOP: begin
            if (cnt_reg == FULL_M1) begin
               cnt_next = '0;
               if (rx_s) begin
                  state_next = IDLE;
                  // An unread byte with no ack this cycle wins; the new byte is dropped.
                  if (valid_reg && !rd_ack) begin
                     ovr_next = 1'b1;
                  end else begin
                     data_next  = shift_reg;
                     valid_next = 1'b1;
                  end
               end else begin
                  fe_next    = 1'b1;
                  state_next = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            cnt_next = '0;
            if (rx_s)
               state_next = IDLE;
         end
         default: begin
            cnt_next   = '0;
            state_next = IDLE;
         end
      endcase
   end

   assign data_out      = data_reg;
   assign data_valid    = valid_reg;
   assign framing_error = fe_reg;
   assign overrun       = ovr_reg;
   assign busy          = (state_reg != IDLE);

endmodule
